// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared fetch-side constants, FSM encoding and helpers for fetch_stall_ctrl.
package fetch_stall_ctrl_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stall_ctrl_if_id_reg.sv
// IF/ID pipeline register: flush loads a NOP bubble, enable low holds contents.
module fetch_stall_ctrl_if_id_reg
  import fetch_stall_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  pc4_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  pc4_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o
);

  logic [ADDR_W-1:0]  pc4_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;

  // Flush wins over enable; pc4 is left as-is on flush since valid=0 marks it dead.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc4_q   <= '0;
      instr_q <= INSTR_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= INSTR_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (en_i) begin
      pc4_q   <= pc4_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch stall/redirect control: PC, IF/ID, load-use hold with watchdog.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MAX_STALL = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_req_i,
  input  logic               branch_taken_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  if_id_pc4_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic               if_id_valid_o,
  output logic               id_ex_bubble_o,
  output logic               stall_active_o,
  output logic               stall_overflow_o,
  output logic [31:0]        perf_stalls_o,
  output logic [31:0]        perf_flushes_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_STALL);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              ovf_q;
  logic              stall_act, advance;

  // GRANT forces one advance so a stuck stall_req cannot starve fetch.
  assign stall_act = ~rst_i & stall_req_i & ~branch_taken_i & (state_q != ST_GRANT);
  assign advance   = ~branch_taken_i & ~stall_act;
  assign pc_inc    = pc_q + ADDR_W'(PC_INC);

  always_comb begin
    pc_d = pc_q;
    if (branch_taken_i) pc_d = branch_target_i;
    else if (advance)   pc_d = pc_inc;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      ovf_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (branch_taken_i) begin
        cnt_q   <= '0;
        state_q <= ST_RUN;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            if (stall_req_i) begin
              cnt_q <= 4'd1;
              if (MAX_CNT == 4'd1) begin
                state_q <= ST_GRANT;
                ovf_q   <= 1'b1;
              end else begin
                state_q <= ST_STALL;
              end
            end
          end
          ST_STALL: begin
            if (stall_req_i) begin
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q + 4'd1 == MAX_CNT) begin
                state_q <= ST_GRANT;
                ovf_q   <= 1'b1;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= ST_RUN;
            end
          end
          ST_GRANT: begin
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        endcase
      end
    end
  end

  fetch_stall_ctrl_if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (advance),
    .flush_i (branch_taken_i),
    .pc4_i   (pc_inc),
    .instr_i (imem_instr_i),
    .pc4_o   (if_id_pc4_o),
    .instr_o (if_id_instr_o),
    .valid_o (if_id_valid_o)
  );

  assign pc_o             = pc_q;
  assign stall_active_o   = stall_act;
  assign id_ex_bubble_o   = ~rst_i & (branch_taken_i | stall_act);
  assign stall_overflow_o = ovf_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stalls_q, perf_flushes_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (stall_act)      perf_stalls_q  <= sat_inc32(perf_stalls_q);
      if (branch_taken_i) perf_flushes_q <= sat_inc32(perf_flushes_q);
    end
  end

  assign perf_stalls_o  = perf_stalls_q;
  assign perf_flushes_o = perf_flushes_q;
`else
  assign perf_stalls_o  = '0;
  assign perf_flushes_o = '0;
`endif

endmodule
